conv1d_mac_core: RTL and testbench
==================================

# conv1d_mac_core

Compute engine behind the CFU command wrapper. It executes the custom-instruction commands the wrapper forwards (funct7 opcode plus two 32-bit operands) for int8 1D convolution: it buffers filter and input words and runs multi-cycle offset-corrected dot products into a 32-bit accumulator. Each command is acknowledged with `output_valid`, and the result is held on `ret`.

## Interface
Parameters:
- `DEPTH`, 256: words per buffer (filter and input); power of two.
- `ADDR_W`, $clog2(DEPTH): buffer address width.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `en` in 1: command request, level; held high until `output_valid` is seen.
- `cmd` in 7: opcode (funct7).
- `inp0` in 32: operand 0.
- `inp1` in 32: operand 1.
- `ret` out 32: command result, registered, held until next command completes.
- `output_valid` out 1: command done; registered.

## Operation
- Storage:
  - `filt_mem[DEPTH]` and `in_mem[DEPTH]`: 32-bit words, each packing 4 signed int8 lanes, lane0 = bits [7:0].
  - `acc`: 32-bit signed accumulator.
  - `offset`: 9-bit signed input offset.
  - `len`: ADDR_W+1 bits.
- Opcodes:
  - 0 CLEAR: `acc`=0; `offset`=inp0[8:0]; `ret`=0.
  - 1 WR_FILT: filt_mem[inp1[ADDR_W-1:0]]=inp0; `ret`=inp0.
  - 2 WR_IN: in_mem[inp1[ADDR_W-1:0]]=inp0; `ret`=inp0.
  - 3 SET_LEN: `len`=min(inp0, DEPTH); `ret`=new `len`.
  - 4 RUN: for k in 0..len-1: `acc` += Σ_lanes (in_mem[(inp0+k) mod DEPTH].lane + offset) × filt_mem[k].lane; `ret`=final `acc`.
  - 5 READ_ACC: `ret`=`acc`; no side effect.
  - Other: no side effect; `ret`=0.
- Arithmetic:
  - Lane sum: int8 + int9, giving a 10-bit signed value.
  - Product: 10b × 8b signed, giving 18 bits.
  - 4-lane sum: 20 bits, sign-extended to 32 bits.
  - `acc` wraps modulo 2^32 with no saturation.
- Input address wraps modulo DEPTH. The filter index always starts at 0.
- FSM states:
  - IDLE: `en`=1 latches `cmd`/`inp0`/`inp1`. Goes to EXEC for non-RUN opcodes; for RUN goes to FETCH if `len`>0, else DRAIN.
  - EXEC: applies the single-cycle opcode, then goes to DONE.
  - FETCH: reads one word pair per cycle; read addresses advance. After `len` reads, goes to DRAIN.
  - DRAIN: finishes the 2-stage pipeline (read, then MAC); last accumulate lands; goes to DONE.
  - DONE: `output_valid`=1, `ret` updated. Stays until `en`=0, then goes to IDLE.
- Return-to-zero handshake: `en` must be low for at least one cycle between commands. `en`, `cmd` and operand changes while not in IDLE are ignored.

## Timing
- Reset (asynchronous, any state):
  - State=IDLE; `output_valid`=0; `ret`=0; `acc`=0; `offset`=0; `len`=0.
  - Buffers are not cleared.
  - Reset mid-RUN abandons the sum, and no `output_valid` follows.
- Single-cycle opcodes: `en` sampled at edge N (IDLE), then EXEC at N+1; `output_valid` and `ret` are valid after edge N+2.
- RUN latency:
  - `len` L > 0: `output_valid` after edge N+L+3. Busy time is L+2 cycles after latch.
  - L = 0: `output_valid` after edge N+3; `acc` unchanged.
- `output_valid` stays high until the edge after `en` is sampled low.
- `ret` is stable from `output_valid` rising until the next command completes.
- Write ports commit at the EXEC edge. A RUN issued on the next command sees the written data.

## Test plan
- Reset state: drive `reset_n`=0 mid-cycle -> `output_valid`=0 and `ret`=0 immediately. After release, READ_ACC -> `ret`=0.
- Basic dot product:
  - Stimulus: CLEAR inp0=0; WR_FILT 0x01010101@0; WR_IN 0x02020202@0; SET_LEN 1; RUN inp0=0.
  - Response: `ret`=8; `output_valid` 4 cycles after latch.
- Offset and signs:
  - CLEAR inp0=128; in=0x80808080; filt=0x7F7F7F7F; RUN -> `ret`=0.
  - CLEAR inp0=0, same data; RUN -> `ret`=−65024 (0xFFFF0200).
- Wrap-around: DEPTH=256; in_mem[255]=0x00000001; in_mem[0]=0x00000003; filt[0]=filt[1]=0x00000002; SET_LEN 2; RUN inp0=255 -> `ret`=8.
- Overflow and length 0:
  - Preload `acc` near 0x7FFFFFF0 via repeated RUN, then add 32 -> `ret` wraps to 0x80000010.
  - SET_LEN 0; RUN -> `ret` unchanged, latency 3.
- Handshake and abort:
  - Hold `en`=1 after done -> `output_valid` stays 1 and no re-execution; READ_ACC is unchanged.
  - Unknown `cmd`=0x7F -> `ret`=0.
  - `reset_n` low during RUN with `len`=200 -> no `output_valid`; `acc`=0.

Source files
------------

// File: rtl/conv1d_mac_core_if.sv
// Command/response bundle between the CFU wrapper (master) and the compute core (slave).
// The wrapper holds en high until output_valid, then drops it for at least one cycle.
interface conv1d_mac_core_if;
  logic        en;
  logic [6:0]  cmd;
  logic [31:0] inp0;
  logic [31:0] inp1;
  logic [31:0] ret;
  logic        output_valid;

  modport master (output en, cmd, inp0, inp1, input ret, output_valid);
  modport slave  (input en, cmd, inp0, inp1, output ret, output_valid);
endinterface

// File: rtl/conv1d_mac_core.sv
// int8 1D-convolution engine: filter/input word buffers plus a multi-cycle
// offset-corrected 4-lane dot product accumulated into a wrapping 32-bit register.
module conv1d_mac_core #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  conv1d_mac_core_if.slave bus
);

  localparam logic [6:0] OP_CLEAR    = 7'd0;
  localparam logic [6:0] OP_WR_FILT  = 7'd1;
  localparam logic [6:0] OP_WR_IN    = 7'd2;
  localparam logic [6:0] OP_SET_LEN  = 7'd3;
  localparam logic [6:0] OP_RUN      = 7'd4;
  localparam logic [6:0] OP_READ_ACC = 7'd5;

  localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_CNT   = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {IDLE, EXEC, FETCH, DRAIN, DONE} state_t;

  state_t state_reg, state_next;

  logic [6:0]        cmd_reg;
  logic [31:0]       op0_reg;
  logic [ADDR_W-1:0] waddr_reg;
  logic [31:0]       acc_reg;
  logic [8:0]        offset_reg;
  logic [ADDR_W:0]   len_reg;
  logic [ADDR_W:0]   rd_cnt_reg;
  logic              drain_cnt_reg;
  logic              rd_valid_reg;
  logic              dot_valid_reg;
  logic [31:0]       dot_reg;
  logic [31:0]       res_reg;
  logic [31:0]       ret_reg;
  logic              valid_reg;

  logic [31:0] filt_mem [DEPTH];
  logic [31:0] in_mem   [DEPTH];
  logic [31:0] filt_rd_reg;
  logic [31:0] in_rd_reg;

  logic              latch;
  logic              exec;
  logic              fetch;
  logic              last_read;
  logic [ADDR_W-1:0] in_addr;
  logic [ADDR_W:0]   len_new;
  logic              filt_we;
  logic              in_we;

  assign latch     = (state_reg == IDLE) && bus.en;
  assign exec      = (state_reg == EXEC);
  assign fetch     = (state_reg == FETCH);
  assign last_read = (rd_cnt_reg == len_reg - ONE_CNT);
  assign in_addr   = op0_reg[ADDR_W-1:0] + rd_cnt_reg[ADDR_W-1:0];
  assign len_new   = (op0_reg >= 32'(DEPTH)) ? DEPTH_LEN : op0_reg[ADDR_W:0];
  assign filt_we   = exec && (cmd_reg == OP_WR_FILT);
  assign in_we     = exec && (cmd_reg == OP_WR_IN);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.en) begin
          if (bus.cmd == OP_RUN) begin
            state_next = (len_reg != '0) ? FETCH : DRAIN;
          end else begin
            state_next = EXEC;
          end
        end
      end
      EXEC:    state_next = DONE;
      FETCH:   if (last_read) state_next = DRAIN;
      DRAIN:   if (drain_cnt_reg) state_next = DONE;
      DONE:    if (!bus.en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Buffers carry no reset so they map onto block RAM with a registered read port.
  always_ff @(posedge clk) begin
    if (filt_we) filt_mem[waddr_reg] <= op0_reg;
    if (fetch)   filt_rd_reg <= filt_mem[rd_cnt_reg[ADDR_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (in_we) in_mem[waddr_reg] <= op0_reg;
    if (fetch) in_rd_reg <= in_mem[in_addr];
  end

  logic signed [7:0]  in_lane   [4];
  logic signed [7:0]  filt_lane [4];
  logic signed [9:0]  lane_sum  [4];
  logic signed [17:0] lane_prod [4];
  logic signed [19:0] dot_sum;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign in_lane[gi]   = in_rd_reg[8*gi +: 8];
      assign filt_lane[gi] = filt_rd_reg[8*gi +: 8];
      assign lane_sum[gi]  = 10'(in_lane[gi]) + 10'($signed(offset_reg));
      assign lane_prod[gi] = 18'(lane_sum[gi]) * 18'(filt_lane[gi]);
    end
  endgenerate

  assign dot_sum = 20'(lane_prod[0]) + 20'(lane_prod[1])
                 + 20'(lane_prod[2]) + 20'(lane_prod[3]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cmd_reg       <= '0;
      op0_reg       <= '0;
      waddr_reg     <= '0;
      acc_reg       <= '0;
      offset_reg    <= '0;
      len_reg       <= '0;
      rd_cnt_reg    <= '0;
      drain_cnt_reg <= 1'b0;
      rd_valid_reg  <= 1'b0;
      dot_valid_reg <= 1'b0;
      dot_reg       <= '0;
      res_reg       <= '0;
      ret_reg       <= '0;
      valid_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (latch) begin
        cmd_reg   <= bus.cmd;
        op0_reg   <= bus.inp0;
        waddr_reg <= bus.inp1[ADDR_W-1:0];
      end

      rd_cnt_reg    <= fetch ? rd_cnt_reg + ONE_CNT : '0;
      drain_cnt_reg <= (state_reg == DRAIN) ? ~drain_cnt_reg : 1'b0;

      // Two-stage MAC pipeline: registered RAM read, then registered 4-lane dot.
      rd_valid_reg  <= fetch;
      dot_valid_reg <= rd_valid_reg;
      dot_reg       <= 32'(dot_sum);
      if (dot_valid_reg) acc_reg <= acc_reg + dot_reg;

      if (exec) begin
        case (cmd_reg)
          OP_CLEAR: begin
            acc_reg    <= '0;
            offset_reg <= op0_reg[8:0];
            res_reg    <= '0;
          end
          OP_WR_FILT, OP_WR_IN: res_reg <= op0_reg;
          OP_SET_LEN: begin
            len_reg <= len_new;
            res_reg <= 32'(len_new);
          end
          OP_READ_ACC: res_reg <= acc_reg;
          default:     res_reg <= '0;
        endcase
      end

      // ret only moves on the first DONE cycle so it holds across the handshake.
      valid_reg <= (state_reg == DONE);
      if ((state_reg == DONE) && !valid_reg) begin
        ret_reg <= (cmd_reg == OP_RUN) ? acc_reg : res_reg;
      end
    end
  end

  assign bus.ret          = ret_reg;
  assign bus.output_valid = valid_reg;

endmodule

// File: tb/tb_conv1d_mac_core.sv
// Bench for conv1d_mac_core: directed vector table, handshake/reset corner sequences,
// accumulator wrap, and random commands checked against an array-based reference model.
module tb_conv1d_mac_core;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  conv1d_mac_core_if bus();

  conv1d_mac_core #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] m_filt [DEPTH];
  logic [31:0] m_in   [DEPTH];
  logic [31:0] m_acc;
  int          m_off;
  int          m_len;

  typedef struct {
    logic [6:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vt [27];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 32'd0;
    m_off = 0;
    m_len = 0;
  endtask

  // Reference: plain integer arithmetic over the buffered words.
  task automatic model_cmd(input logic [6:0] c, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output int lat);
    int          sum;
    logic [31:0] w_in, w_f;
    logic signed [7:0] x, f;
    lat = 2;
    r   = 32'd0;
    case (c)
      7'd0: begin m_acc = 32'd0; m_off = int'($signed(a[8:0])); r = 32'd0; end
      7'd1: begin m_filt[b % DEPTH] = a; r = a; end
      7'd2: begin m_in[b % DEPTH] = a; r = a; end
      7'd3: begin m_len = (a >= DEPTH) ? DEPTH : int'(a); r = m_len; end
      7'd4: begin
        sum = 0;
        for (int k = 0; k < m_len; k++) begin
          w_in = m_in[(a + k) % DEPTH];
          w_f  = m_filt[k];
          for (int l = 0; l < 4; l++) begin
            x = w_in[8*l +: 8];
            f = w_f[8*l +: 8];
            sum += (int'(x) + m_off) * int'(f);
          end
        end
        m_acc = m_acc + sum;
        r     = m_acc;
        lat   = m_len + 3;
      end
      7'd5:    r = m_acc;
      default: r = 32'd0;
    endcase
  endtask

  task automatic do_cmd(input logic [6:0] c, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output logic [31:0] r, output int lat);
    int guard;
    int hold_bad;
    @(negedge clk);
    bus.en = 1'b1; bus.cmd = c; bus.inp0 = a; bus.inp1 = b;
    @(posedge clk);
    #1;
    // Operands must be ignored once the command is latched.
    bus.cmd = 7'($urandom); bus.inp0 = $urandom; bus.inp1 = $urandom;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (bus.output_valid !== 1'b1 && lat < 1000);
    if (bus.output_valid !== 1'b1) begin
      tests++; fails++;
      $display("FAIL done_timeout cmd=%0d: no output_valid within %0d cycles", c, lat);
    end
    r = bus.ret;
    hold_bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (bus.output_valid !== 1'b1 || bus.ret !== r) hold_bad++;
    end
    if (hold > 0) check("hold_stable_cycles_bad", hold_bad, 0);
    @(negedge clk);
    bus.en = 1'b0;
    guard = 0;
    while (bus.output_valid === 1'b1 && guard < 10) begin
      @(posedge clk); #1; guard++;
    end
    if (bus.output_valid === 1'b1) begin
      tests++; fails++;
      $display("FAIL valid_drop_timeout cmd=%0d: output_valid still 1", c);
    end
  endtask

  task automatic run_and_check(input logic [6:0] c, input logic [31:0] a, input logic [31:0] b,
                               input int hold, input string name, output logic [31:0] r);
    logic [31:0] er;
    int el, lat;
    model_cmd(c, a, b, er, el);
    do_cmd(c, a, b, hold, r, lat);
    $display("[TB] %s cmd=%02h inp0=%08h inp1=%08h ret=%08h lat=%0d", name, c, a, b, r, lat);
    check({name, "_ret"}, r, er);
    check({name, "_lat"}, lat, el);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] a, b;
    logic [6:0]  c;
    int          sel, lat, seen;

    vt[0]  = '{7'd5,  32'd0,          32'd0,   32'd0,          2};
    vt[1]  = '{7'd0,  32'd0,          32'd0,   32'd0,          2};
    vt[2]  = '{7'd1,  32'h01010101,   32'd0,   32'h01010101,   2};
    vt[3]  = '{7'd2,  32'h02020202,   32'd0,   32'h02020202,   2};
    vt[4]  = '{7'd3,  32'd1,          32'd0,   32'd1,          2};
    vt[5]  = '{7'd4,  32'd0,          32'd0,   32'd8,          4};
    vt[6]  = '{7'd5,  32'd0,          32'd0,   32'd8,          2};
    vt[7]  = '{7'd0,  32'd128,        32'd0,   32'd0,          2};
    vt[8]  = '{7'd2,  32'h80808080,   32'd0,   32'h80808080,   2};
    vt[9]  = '{7'd1,  32'h7F7F7F7F,   32'd0,   32'h7F7F7F7F,   2};
    vt[10] = '{7'd4,  32'd0,          32'd0,   32'd0,          4};
    vt[11] = '{7'd0,  32'd0,          32'd0,   32'd0,          2};
    vt[12] = '{7'd4,  32'd0,          32'd0,   32'hFFFF0200,   4};
    vt[13] = '{7'd0,  32'd0,          32'd0,   32'd0,          2};
    vt[14] = '{7'd2,  32'd1,          32'd255, 32'd1,          2};
    vt[15] = '{7'd2,  32'd3,          32'd0,   32'd3,          2};
    vt[16] = '{7'd1,  32'd2,          32'd0,   32'd2,          2};
    vt[17] = '{7'd1,  32'd2,          32'h301, 32'd2,          2};
    vt[18] = '{7'd3,  32'd2,          32'd0,   32'd2,          2};
    vt[19] = '{7'd4,  32'd255,        32'd0,   32'd8,          5};
    vt[20] = '{7'd3,  32'h00001000,   32'd0,   32'd256,        2};
    vt[21] = '{7'd3,  32'hFFFFFFFF,   32'd0,   32'd256,        2};
    vt[22] = '{7'd3,  32'd0,          32'd0,   32'd0,          2};
    vt[23] = '{7'd4,  32'd7,          32'd0,   32'd8,          3};
    vt[24] = '{7'h7F, 32'd5,          32'd5,   32'd0,          2};
    vt[25] = '{7'd6,  32'd1,          32'd1,   32'd0,          2};
    vt[26] = '{7'd5,  32'd0,          32'd0,   32'd8,          2};

    bus.en = 1'b0; bus.cmd = '0; bus.inp0 = '0; bus.inp1 = '0;
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", bus.output_valid, 1'b0);
    check("reset_ret", bus.ret, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 27; i++) begin
      logic [31:0] er;
      int el;
      model_cmd(vt[i].c, vt[i].a, vt[i].b, er, el);
      do_cmd(vt[i].c, vt[i].a, vt[i].b, 0, r, lat);
      $display("[TB] vec%0d cmd=%02h inp0=%08h inp1=%08h ret=%08h lat=%0d",
               i, vt[i].c, vt[i].a, vt[i].b, r, lat);
      check($sformatf("vec%0d_ret", i), r, vt[i].exp);
      check($sformatf("vec%0d_lat", i), lat, vt[i].lat);
    end

    // Asynchronous reset mid-cycle while output_valid is high
    @(negedge clk);
    bus.en = 1'b1; bus.cmd = 7'd5; bus.inp0 = '0; bus.inp1 = '0;
    seen = 0;
    while (bus.output_valid !== 1'b1 && seen < 20) begin
      @(posedge clk); #1; seen++;
    end
    check("pre_reset_valid", bus.output_valid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_valid", bus.output_valid, 1'b0);
    check("async_reset_ret", bus.ret, 32'd0);
    bus.en = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_and_check(7'd5, 32'd0, 32'd0, 0, "post_reset_read", r);

    // Holding en after completion must neither drop valid nor re-run
    run_and_check(7'd3, 32'd2, 32'd0, 0, "hold_setlen", r);
    run_and_check(7'd4, 32'd255, 32'd0, 10, "hold_run", r);
    run_and_check(7'd5, 32'd0, 32'd0, 0, "hold_readback", r);

    // Fill buffers so each word contributes 0x20000, then wrap the accumulator
    run_and_check(7'd0, 32'h00000100, 32'd0, 0, "ovf_clear", r);
    for (int i = 0; i < DEPTH; i++) begin
      run_and_check(7'd1, 32'h80808080, 32'(i), 0, "ovf_wr_filt", r);
      run_and_check(7'd2, 32'h00000000, 32'(i), 0, "ovf_wr_in", r);
    end
    run_and_check(7'd3, 32'd256, 32'd0, 0, "ovf_setlen", r);
    for (int i = 0; i < 64; i++) begin
      run_and_check(7'd4, $urandom, 32'd0, 0, "ovf_run", r);
    end
    check("ovf_acc_2pow31", r, 32'h80000000);
    run_and_check(7'd1, 32'h0000FF01, 32'd0, 0, "ovf_fine_filt", r);
    run_and_check(7'd3, 32'd1, 32'd0, 0, "ovf_len1", r);
    run_and_check(7'd2, 32'h00001000, 32'd0, 0, "ovf_in_m16", r);
    run_and_check(7'd4, 32'd0, 32'd0, 0, "ovf_sub16", r);
    check("ovf_near_max", r, 32'h7FFFFFF0);
    run_and_check(7'd2, 32'h00000020, 32'd1, 0, "ovf_in_p32", r);
    run_and_check(7'd4, 32'd1, 32'd0, 0, "ovf_add32", r);
    check("ovf_wrapped", r, 32'h80000010);

    // Random commands against the reference model
    for (int i = 0; i < 120; i++) begin
      sel = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      case (sel)
        0:       c = 7'd0;
        1, 2:    begin c = 7'd1; b = (b & 32'hFFFFFF00) | 32'($urandom_range(0, 15)); end
        3, 4:    begin c = 7'd2; b = (b & 32'hFFFFFF00) | 32'($urandom_range(0, 15)); end
        5:       begin c = 7'd3; if ($urandom_range(0, 3) != 0) a = 32'($urandom_range(0, 16)); end
        6, 7:    c = 7'd4;
        8:       c = 7'd5;
        default: c = 7'($urandom_range(6, 127));
      endcase
      run_and_check(c, a, b, 0, "rand", r);
    end

    // Reset in the middle of a long RUN abandons it
    run_and_check(7'd3, 32'd200, 32'd0, 0, "abort_setlen", r);
    @(negedge clk);
    bus.en = 1'b1; bus.cmd = 7'd4; bus.inp0 = 32'd3; bus.inp1 = '0;
    seen = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (bus.output_valid === 1'b1) seen++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_valid_in_reset", bus.output_valid, 1'b0);
    bus.en = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (210) begin
      @(posedge clk); #1;
      if (bus.output_valid === 1'b1) seen++;
    end
    check("abort_no_valid", seen, 0);
    run_and_check(7'd5, 32'd0, 32'd0, 0, "abort_acc", r);
    run_and_check(7'd4, 32'd0, 32'd0, 0, "abort_len0_run", r);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
